// File: rtl/axis_matrix_feeder.sv
// Host-side feeder for the 2xK by Kx2 matrix engine: holds operands A and B,
// streams them out over AXI-Stream, then collects the 4-word C result.
module axis_matrix_feeder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned K_MAX  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [$clog2(2*K_MAX)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [15:0]                   cfg_k,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [DATA_W-1:0]             m_axis_a_tdata,
  output logic                          m_axis_a_tvalid,
  input  logic                          m_axis_a_tready,
  output logic                          m_axis_a_tlast,
  output logic [DATA_W-1:0]             m_axis_b_tdata,
  output logic                          m_axis_b_tvalid,
  input  logic                          m_axis_b_tready,
  output logic                          m_axis_b_tlast,
  input  logic [DATA_W-1:0]             s_axis_c_tdata,
  input  logic                          s_axis_c_tvalid,
  output logic                          s_axis_c_tready,
  input  logic                          s_axis_c_tlast,
  input  logic [1:0]                    c_rd_addr,
  output logic [DATA_W-1:0]             c_rd_data
);

  localparam int unsigned AW    = $clog2(2*K_MAX);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 2*K_MAX;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND_A = 3'd1,
    S_SEND_B = 3'd2,
    S_RECV_C = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [15:0]       r_k;
  logic              r_err;
  logic [DATA_W-1:0] r_a_mem [DEPTH];
  logic [DATA_W-1:0] r_b_mem [DEPTH];
  logic [DATA_W-1:0] r_c     [4];

  logic              w_k_ok;
  logic [16:0]       w_last_idx;
  logic              w_last_beat;
  logic              w_cnt_is3;
  logic              w_wr_ok;
  logic              w_k_ld;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_err_set;
  logic              w_err_clr;
  logic              w_c_wr;

  // Range check on the full 16-bit request so oversized K cannot alias
  assign w_k_ok      = (cfg_k != 16'd0) && (cfg_k <= 16'(K_MAX));
  assign w_last_idx  = ({1'b0, r_k} << 1) - 17'd1;
  assign w_last_beat = (17'(r_cnt) == w_last_idx);
  assign w_cnt_is3   = (r_cnt == CW'(3));
  assign w_wr_ok     = (r_state == S_IDLE) || (r_state == S_DONE);

  // Stream and status outputs are decoded from state/counter registers only
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);
  assign err             = r_err;
  assign m_axis_a_tvalid = (r_state == S_SEND_A);
  assign m_axis_a_tdata  = r_a_mem[r_cnt[AW-1:0]];
  assign m_axis_a_tlast  = m_axis_a_tvalid && w_last_beat;
  assign m_axis_b_tvalid = (r_state == S_SEND_B);
  assign m_axis_b_tdata  = r_b_mem[r_cnt[AW-1:0]];
  assign m_axis_b_tlast  = m_axis_b_tvalid && w_last_beat;
  assign s_axis_c_tready = (r_state == S_RECV_C);
  assign c_rd_data       = r_c[c_rd_addr];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath control decode
  always_comb begin
    w_state_nxt = r_state;
    w_k_ld      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_c_wr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_k_ld    = 1'b1;
          w_err_clr = 1'b1;
          w_cnt_clr = 1'b1;
          if (w_k_ok) begin
            w_state_nxt = S_SEND_A;
          end else begin
            w_err_set   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_SEND_A: begin
        if (m_axis_a_tready) begin
          if (w_last_beat) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_SEND_B;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_SEND_B: begin
        if (m_axis_b_tready) begin
          if (w_last_beat) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_RECV_C;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_RECV_C: begin
        if (s_axis_c_tvalid) begin
          w_c_wr    = 1'b1;
          // tlast must coincide exactly with the fourth beat
          w_err_set = s_axis_c_tlast ^ w_cnt_is3;
          if (s_axis_c_tlast || w_cnt_is3) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beat counter, latched K, sticky error and C result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_k   <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < 4; i++) r_c[i] <= '0;
    end else begin
      if (w_k_ld)         r_k <= cfg_k;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
      if (w_c_wr)         r_c[r_cnt[1:0]] <= s_axis_c_tdata;
    end
  end

  // Operand memories: host writes land only while no transfer is in flight
  always_ff @(posedge clk) begin
    if (wr_en && w_wr_ok) begin
      if (wr_sel) r_b_mem[wr_addr] <= wr_data;
      else        r_a_mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_axis_matrix_feeder.sv
// Self-checking bench for axis_matrix_feeder: queue-based stream model,
// per-cycle output compare, directed scenarios and randomized runs.
module tb_axis_matrix_feeder;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned K_MAX  = 64;
  localparam int unsigned DEPTH  = 2*K_MAX;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic              wr_sel;
  logic [6:0]        wr_addr;
  logic [31:0]       wr_data;
  logic [15:0]       cfg_k;
  logic              start;
  logic              busy, done, err;
  logic [31:0]       m_axis_a_tdata, m_axis_b_tdata;
  logic              m_axis_a_tvalid, m_axis_a_tready, m_axis_a_tlast;
  logic              m_axis_b_tvalid, m_axis_b_tready, m_axis_b_tlast;
  logic [31:0]       s_axis_c_tdata;
  logic              s_axis_c_tvalid, s_axis_c_tready, s_axis_c_tlast;
  logic [1:0]        c_rd_addr;
  logic [31:0]       c_rd_data;

  // directed and noise write ports, merged onto the DUT write port
  logic        t_wr_en, t_wr_sel;
  logic [6:0]  t_wr_addr;
  logic [31:0] t_wr_data;
  logic        n_wr_en, n_wr_sel;
  logic [6:0]  n_wr_addr;
  logic [31:0] n_wr_data;

  assign wr_en   = t_wr_en | n_wr_en;
  assign wr_sel  = n_wr_en ? n_wr_sel  : t_wr_sel;
  assign wr_addr = n_wr_en ? n_wr_addr : t_wr_addr;
  assign wr_data = n_wr_en ? n_wr_data : t_wr_data;

  axis_matrix_feeder #(.DATA_W(DATA_W), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_k(cfg_k), .start(start), .busy(busy), .done(done), .err(err),
    .m_axis_a_tdata(m_axis_a_tdata), .m_axis_a_tvalid(m_axis_a_tvalid),
    .m_axis_a_tready(m_axis_a_tready), .m_axis_a_tlast(m_axis_a_tlast),
    .m_axis_b_tdata(m_axis_b_tdata), .m_axis_b_tvalid(m_axis_b_tvalid),
    .m_axis_b_tready(m_axis_b_tready), .m_axis_b_tlast(m_axis_b_tlast),
    .s_axis_c_tdata(s_axis_c_tdata), .s_axis_c_tvalid(s_axis_c_tvalid),
    .s_axis_c_tready(s_axis_c_tready), .s_axis_c_tlast(s_axis_c_tlast),
    .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data)
  );

  // model state
  logic [31:0] mdl_a [DEPTH];
  logic [31:0] mdl_b [DEPTH];
  logic [31:0] exp_c [4];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] a_log[$];
  logic [31:0] b_log[$];
  int          a_cyc[$];
  int          b_cyc[$];
  logic        c_open;
  logic        exp_err;
  logic [31:0] cd [4];
  logic        cl [4];
  int          cn;
  int          cyc;
  int          start_cyc;
  int          rdy_mode;
  logic        noise_en;
  int          n_chk;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic finish_tb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sink ready patterns: 0 always, 1 A toggles, 2 random, 3 B held off
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin m_axis_a_tready <= 1'b1; m_axis_b_tready <= 1'b1; end
      1: begin m_axis_a_tready <= ~m_axis_a_tready; m_axis_b_tready <= 1'b1; end
      2: begin
        m_axis_a_tready <= 1'($urandom_range(0, 1));
        m_axis_b_tready <= 1'($urandom_range(0, 1));
      end
      default: begin m_axis_a_tready <= 1'b1; m_axis_b_tready <= 1'b0; end
    endcase
  end

  // Stray writes while a transfer is in flight; the model ignores them
  always @(negedge clk) begin
    if (noise_en && busy && !done && $urandom_range(0, 1) == 1) begin
      n_wr_en   <= 1'b1;
      n_wr_sel  <= 1'($urandom_range(0, 1));
      n_wr_addr <= 7'($urandom);
      n_wr_data <= $urandom;
    end else begin
      n_wr_en <= 1'b0;
    end
  end

  // Per-cycle compare of the stream outputs against the expected queues
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_a_tvalid && m_axis_b_tvalid) chk("ab_overlap", 32'd1, 32'd0);
      if (m_axis_a_tvalid) begin
        if (exp_a.size() == 0) begin
          chk("a_unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("a_tdata", m_axis_a_tdata, exp_a[0]);
          chk("a_tlast", 32'(m_axis_a_tlast), 32'(exp_a.size() == 1));
          if (m_axis_a_tready) begin
            a_log.push_back(m_axis_a_tdata);
            a_cyc.push_back(cyc);
            void'(exp_a.pop_front());
          end
        end
      end
      if (m_axis_b_tvalid) begin
        if (exp_b.size() == 0 || exp_a.size() != 0) begin
          chk("b_unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("b_tdata", m_axis_b_tdata, exp_b[0]);
          chk("b_tlast", 32'(m_axis_b_tlast), 32'(exp_b.size() == 1));
          if (m_axis_b_tready) begin
            b_log.push_back(m_axis_b_tdata);
            b_cyc.push_back(cyc);
            void'(exp_b.pop_front());
          end
        end
      end
      if (s_axis_c_tready && !(c_open && exp_a.size() == 0 && exp_b.size() == 0))
        chk("c_ready_early", 32'd1, 32'd0);
    end
  end

  task automatic clear_model();
    exp_a.delete();
    exp_b.delete();
    c_open = 1'b0;
    for (int i = 0; i < 4; i++) exp_c[i] = '0;
  endtask

  task automatic write_mem(input logic sel, input int addr, input logic [31:0] d);
    t_wr_en   = 1'b1;
    t_wr_sel  = sel;
    t_wr_addr = 7'(addr);
    t_wr_data = d;
    tick();
    t_wr_en = 1'b0;
    if (sel) mdl_b[addr] = d;
    else     mdl_a[addr] = d;
  endtask

  task automatic start_run(input logic [15:0] k);
    cfg_k     = k;
    start     = 1'b1;
    start_cyc = cyc;
    a_log.delete(); b_log.delete(); a_cyc.delete(); b_cyc.delete();
    if (k >= 16'd1 && k <= 16'(K_MAX)) begin
      for (int i = 0; i < 2*int'(k); i++) begin
        exp_a.push_back(mdl_a[i]);
        exp_b.push_back(mdl_b[i]);
      end
      c_open = 1'b1;
    end
    tick();
    start = 1'b0;
    cfg_k = 16'($urandom);
  endtask

  // Drive cn C beats from cd/cl; the model decides results and err
  task automatic send_c();
    logic acc;
    exp_err = 1'b0;
    for (int i = 0; i < cn; i++) begin
      exp_c[i] = cd[i];
      if (cl[i] != (i == 3)) exp_err = 1'b1;
    end
    for (int i = 0; i < cn; i++) begin
      s_axis_c_tvalid = 1'b0;
      if (noise_en) repeat ($urandom_range(0, 2)) tick();
      s_axis_c_tvalid = 1'b1;
      s_axis_c_tdata  = cd[i];
      s_axis_c_tlast  = cl[i];
      acc = 1'b0;
      for (int w = 0; w < 3000 && !acc; w++) begin
        @(negedge clk);
        acc = s_axis_c_tready;
        @(posedge clk);
        #1;
        start = (noise_en && !acc) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!acc) begin
        chk("c_beat_timeout", 32'd0, 32'd1);
        finish_tb();
      end
    end
    s_axis_c_tvalid = 1'b0;
    s_axis_c_tlast  = 1'b0;
    start  = 1'b0;
    c_open = 1'b0;
    chk("done_after_c", 32'(done), 32'd1);
    chk("err_after_c", 32'(err), 32'(exp_err));
  endtask

  task automatic check_c();
    for (int i = 0; i < 4; i++) begin
      c_rd_addr = 2'(i);
      #1;
      chk("c_rd_data", c_rd_data, exp_c[i]);
    end
  endtask

  task automatic chk_c_lit(input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
    c_rd_addr = 2'd0; #1; chk("c_lit0", c_rd_data, v0);
    c_rd_addr = 2'd1; #1; chk("c_lit1", c_rd_data, v1);
    c_rd_addr = 2'd2; #1; chk("c_lit2", c_rd_data, v2);
    c_rd_addr = 2'd3; #1; chk("c_lit3", c_rd_data, v3);
  endtask

  task automatic set_c(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input int n, input int last_at);
    cd[0] = d0; cd[1] = d1; cd[2] = d2; cd[3] = d3;
    for (int i = 0; i < 4; i++) cl[i] = (i == last_at);
    cn = n;
  endtask

  task automatic full_run(input logic [15:0] k);
    start_run(k);
    send_c();
    check_c();
    tick();
    chk("a_all_sent", 32'(exp_a.size()), 32'd0);
    chk("b_all_sent", 32'(exp_b.size()), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic bad_run(input logic [15:0] k);
    start_run(k);
    chk("bad_done", 32'(done), 32'd1);
    chk("bad_err", 32'(err), 32'd1);
    tick();
    chk("bad_idle", 32'(busy), 32'd0);
    chk("bad_err_sticky", 32'(err), 32'd1);
    chk("bad_no_beats", 32'(a_log.size() + b_log.size()), 32'd0);
    check_c();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    #900000;
    chk("watchdog", 32'd0, 32'd1);
    finish_tb();
  end

  initial begin
    logic found;
    logic [15:0] k;
    int sc;
    n_chk = 0; n_fail = 0; cyc = 0; rdy_mode = 0; noise_en = 1'b0;
    rst = 1'b1; start = 1'b0; cfg_k = '0; c_rd_addr = '0;
    t_wr_en = 1'b0; t_wr_sel = 1'b0; t_wr_addr = '0; t_wr_data = '0;
    s_axis_c_tvalid = 1'b0; s_axis_c_tdata = '0; s_axis_c_tlast = 1'b0;
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    n_wr_en = 1'b0; n_wr_sel = 1'b0; n_wr_addr = '0; n_wr_data = '0;
    c_open = 1'b0; exp_err = 1'b0;
    do_reset();

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'({m_axis_a_tvalid, m_axis_b_tvalid, s_axis_c_tready}), 32'd0);
    chk("rst_tlast", 32'({m_axis_a_tlast, m_axis_b_tlast}), 32'd0);
    chk_c_lit(0, 0, 0, 0);

    // K=2 basic run, sinks always ready
    write_mem(0, 0, 1); write_mem(0, 1, 2); write_mem(0, 2, 3); write_mem(0, 3, 4);
    write_mem(1, 0, 5); write_mem(1, 1, 8); write_mem(1, 2, 6); write_mem(1, 3, 9);
    set_c(10, 20, 30, 40, 4, 3);
    full_run(16'd2);
    chk("basic_a_count", 32'(a_log.size()), 32'd4);
    if (a_log.size() == 4 && b_log.size() == 4) begin
      chk("basic_a0", a_log[0], 1); chk("basic_a3", a_log[3], 4);
      chk("basic_b1", b_log[1], 8); chk("basic_b3", b_log[3], 9);
      chk("basic_a_first_cyc", 32'(a_cyc[0]), 32'(start_cyc + 1));
      chk("basic_b_first_cyc", 32'(b_cyc[0]), 32'(start_cyc + 5));
    end
    chk_c_lit(10, 20, 30, 40);

    // same run with A tready toggling
    rdy_mode = 1;
    full_run(16'd2);
    chk("toggle_a_count", 32'(a_log.size()), 32'd4);
    if (a_log.size() == 4 && b_cyc.size() > 0)
      chk("toggle_b_after_a", 32'(b_cyc[0]), 32'(a_cyc[3] + 1));
    rdy_mode = 0;

    // out-of-range K, then a good run clears err
    bad_run(16'd0);
    bad_run(16'd65);
    set_c(11, 22, 33, 44, 4, 3);
    full_run(16'd2);

    // early tlast on third beat
    do_reset();
    set_c(7, 8, 9, 0, 3, 2);
    full_run(16'd2);
    chk_c_lit(7, 8, 9, 0);

    // reset while B is stalled, then retransmit from index 0
    rdy_mode = 3;
    start_run(16'd2);
    found = 1'b0;
    for (int w = 0; w < 100 && !found; w++) begin
      if (m_axis_b_tvalid) found = 1'b1;
      else tick();
    end
    chk("stall_b_seen", 32'(found), 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'({m_axis_a_tvalid, m_axis_b_tvalid, s_axis_c_tready}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    clear_model();
    chk_c_lit(0, 0, 0, 0);
    rdy_mode = 0;
    set_c(10, 20, 30, 40, 4, 3);
    full_run(16'd2);
    if (a_log.size() > 0 && b_log.size() > 0) begin
      chk("restart_a0", a_log[0], 1);
      chk("restart_b0", b_log[0], 5);
    end

    // K = K_MAX with A[i] = i
    for (int i = 0; i < 128; i++) write_mem(0, i, 32'(i));
    for (int i = 0; i < 128; i++) write_mem(1, i, 32'(i + 1000));
    rdy_mode = 2;
    set_c(1, 2, 3, 4, 4, 3);
    full_run(16'd64);
    chk("kmax_a_count", 32'(a_log.size()), 32'd128);
    chk("kmax_b_count", 32'(b_log.size()), 32'd128);
    if (a_log.size() == 128 && b_log.size() == 128) begin
      chk("kmax_a_last", a_log[127], 127);
      chk("kmax_b_last", b_log[127], 1127);
    end

    // randomized runs with stray writes and start toggles while busy
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: k = 16'd0;
          1: k = 16'd65;
          2: k = 16'd300;
          default: k = 16'hFFFF;
        endcase
      end else begin
        k = 16'($urandom_range(1, 64));
        for (int i = 0; i < 2*int'(k); i++) begin
          if ($urandom_range(0, 2) != 0) write_mem(0, i, $urandom);
          if ($urandom_range(0, 2) != 0) write_mem(1, i, $urandom);
        end
      end
      rdy_mode = 2;
      noise_en = 1'b1;
      if (k == 16'd0 || k > 16'd64) begin
        bad_run(k);
      end else begin
        sc = $urandom_range(0, 3);
        if (sc == 2) begin
          sc = $urandom_range(0, 2);
          set_c($urandom, $urandom, $urandom, $urandom, sc + 1, sc);
        end else if (sc == 3) begin
          set_c($urandom, $urandom, $urandom, $urandom, 4, 7);
        end else begin
          set_c($urandom, $urandom, $urandom, $urandom, 4, 3);
        end
        full_run(k);
      end
      noise_en = 1'b0;
      tick();
    end

    finish_tb();
  end

endmodule
